// File: rtl/qtu_pkt_scheduler.sv
// Packet queue and sequencer for the Q-table update engine: filters packet types,
// buffers accepted packets, and runs the en/done handshake. Optional macro QTU_TIMEOUT_EN adds a WAIT abort.
module qtu_pkt_scheduler #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          pkt_valid,
  output logic                          pkt_ready,
  input  logic [15:0]                   pkt_source_id,
  input  logic [15:0]                   pkt_cluster_id,
  input  logic [15:0]                   pkt_energy,
  input  logic [15:0]                   pkt_qvalue,
  input  logic [2:0]                    pkt_type,
  output logic [15:0]                   fSourceID,
  output logic [15:0]                   fClusterID,
  output logic [15:0]                   fEnergyLeft,
  output logic [15:0]                   fQValue,
  output logic [2:0]                    fPacketType,
  output logic                          qtu_en,
  input  logic                          qtu_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    drop_count,
  output logic                          timeout_flag
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [15:0] srcId;
    logic [15:0] clusterId;
    logic [15:0] energy;
    logic [15:0] qValue;
    logic [2:0]  pktType;
  } pkt_t;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  state_t             state, nextState;
  pkt_t               mem [FIFO_DEPTH];
  pkt_t               inPkt, hold;
  logic [PTR_W-1:0]   wrPtr, rdPtr;
  logic               accept, typeOk, push, drop, pop;

  assign inPkt     = '{pkt_source_id, pkt_cluster_id, pkt_energy, pkt_qvalue, pkt_type};
  assign pkt_ready = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign accept    = pkt_valid & pkt_ready;
  assign typeOk    = (pkt_type == 3'd1) || (pkt_type == 3'd2);
  assign push      = accept & typeOk;
  assign drop      = accept & ~typeOk;
  assign pop       = (state == S_IDLE) && (fifo_count != '0);

  assign fSourceID   = hold.srcId;
  assign fClusterID  = hold.clusterId;
  assign fEnergyLeft = hold.energy;
  assign fQValue     = hold.qValue;
  assign fPacketType = hold.pktType;

`ifdef QTU_TIMEOUT_EN
  logic [15:0] waitCnt;
  logic        toFire;

  // A coincident done takes priority, so the abort only fires with done low.
  assign toFire = (state == S_WAIT) && !qtu_done && (waitCnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      waitCnt      <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (state == S_START)     waitCnt <= '0;
      else if (state == S_WAIT) waitCnt <= waitCnt + 16'd1;
      if (toFire) timeout_flag <= 1'b1;
    end
  end
`else
  assign timeout_flag = 1'b0;
`endif

  always_comb begin
    nextState = state;
    qtu_en    = 1'b0;
    busy      = 1'b1;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (pop) nextState = S_START;
      end
      S_START: begin
        qtu_en    = 1'b1;
        nextState = S_WAIT;
      end
      S_WAIT: begin
        if (qtu_done) nextState = S_IDLE;
`ifdef QTU_TIMEOUT_EN
        else if (toFire) nextState = S_IDLE;
`endif
      end
      default: nextState = S_IDLE;
    endcase
  end

  // Storage has no reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= inPkt;
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state      <= S_IDLE;
      wrPtr      <= '0;
      rdPtr      <= '0;
      fifo_count <= '0;
      drop_count <= '0;
      hold       <= '0;
    end else begin
      state <= nextState;
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
        hold  <= mem[rdPtr];
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_qtu_pkt_scheduler.sv
// Scoreboard bench for qtu_pkt_scheduler: stimulus queues expected engine operands,
// a monitor compares them at each qtu_en pulse.
module tb_qtu_pkt_scheduler;
  logic        clk = 1'b0;
  logic        nrst;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [15:0] pkt_source_id, pkt_cluster_id, pkt_energy, pkt_qvalue;
  logic [2:0]  pkt_type;
  logic [15:0] fSourceID, fClusterID, fEnergyLeft, fQValue;
  logic [2:0]  fPacketType;
  logic        qtu_en, qtu_done, busy, timeout_flag;
  logic [2:0]  fifo_count;
  logic [7:0]  drop_count;

  int compared   = 0;
  int mismatched = 0;
  logic [66:0] sb [$];

  qtu_pkt_scheduler #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .nrst(nrst), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_source_id(pkt_source_id), .pkt_cluster_id(pkt_cluster_id),
    .pkt_energy(pkt_energy), .pkt_qvalue(pkt_qvalue), .pkt_type(pkt_type),
    .fSourceID(fSourceID), .fClusterID(fClusterID), .fEnergyLeft(fEnergyLeft),
    .fQValue(fQValue), .fPacketType(fPacketType), .qtu_en(qtu_en),
    .qtu_done(qtu_done), .busy(busy), .fifo_count(fifo_count),
    .drop_count(drop_count), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: each qtu_en pulse consumes one expected packet; operands must stay put while busy.
  logic [66:0] held;
  logic        prevEn = 1'b0;
  always @(negedge clk) begin
    if (!nrst) begin
      if (qtu_en) begin
        if (prevEn) check("qtu_en_width", 32'd2, 32'd1);
        if (sb.size() == 0) begin
          check("unexpected_qtu_en", {25'd0, fPacketType, fSourceID}, 32'd0);
        end else begin
          logic [66:0] exp;
          exp = sb.pop_front();
          held = {fSourceID, fClusterID, fEnergyLeft, fQValue, fPacketType};
          check("pkt_src",  {16'd0, fSourceID},   {16'd0, exp[66:51]});
          check("pkt_clu",  {16'd0, fClusterID},  {16'd0, exp[50:35]});
          check("pkt_nrg",  {16'd0, fEnergyLeft}, {16'd0, exp[34:19]});
          check("pkt_q",    {16'd0, fQValue},     {16'd0, exp[18:3]});
          check("pkt_type", {29'd0, fPacketType}, {29'd0, exp[2:0]});
        end
      end else if (busy) begin
        if ({fSourceID, fClusterID, fEnergyLeft, fQValue, fPacketType} !== held)
          check("f_stable", {16'd0, fSourceID}, {16'd0, held[66:51]});
      end
    end
    prevEn <= qtu_en & ~nrst;
  end

  task automatic sendPkt(input logic [15:0] src, input logic [2:0] typ, input logic [15:0] q);
    int n;
    n = 0;
    pkt_valid = 1'b1; pkt_source_id = src; pkt_cluster_id = src ^ 16'h0A00;
    pkt_energy = src + 16'h0100; pkt_qvalue = q; pkt_type = typ;
    while (!pkt_ready && n < 50) begin tick(1); n++; end
    if (n >= 50) check("send_timeout", 32'd0, 32'd1);
    else if (typ == 3'd1 || typ == 3'd2)
      sb.push_back({src, src ^ 16'h0A00, src + 16'h0100, q, typ});
    tick(1);
    pkt_valid = 1'b0;
  endtask

  task automatic waitEn();
    int n;
    n = 0;
    while (!qtu_en && n < 20) begin tick(1); n++; end
    if (n >= 20) check("wait_en_timeout", 32'd0, 32'd1);
  endtask

  // Wait for S_WAIT (busy without en), then one-cycle done.
  task automatic completeOne();
    int n;
    n = 0;
    while (!(busy && !qtu_en) && n < 20) begin tick(1); n++; end
    if (n >= 20) check("wait_busy_timeout", 32'd0, 32'd1);
    qtu_done = 1'b1;
    tick(1);
    qtu_done = 1'b0;
  endtask

  task automatic doReset();
    nrst = 1'b1;
    tick(2);
    nrst = 1'b0;
    tick(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b1; pkt_valid = 1'b0; qtu_done = 1'b0;
    pkt_source_id = '0; pkt_cluster_id = '0; pkt_energy = '0; pkt_qvalue = '0; pkt_type = '0;
    tick(2);
    check("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
    check("rst_drop_count", {24'd0, drop_count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_en", {31'd0, qtu_en}, 32'd0);
    check("rst_ready", {31'd0, pkt_ready}, 32'd1);
    check("rst_fsrc", {16'd0, fSourceID}, 32'd0);
    check("rst_tflag", {31'd0, timeout_flag}, 32'd0);
    nrst = 1'b0;
    tick(1);

    // single packet latency: accept edge E, en high after E+1
    sendPkt(16'h0005, 3'd1, 16'h0040);
    check("t1_en_early", {31'd0, qtu_en}, 32'd0);
    check("t1_count", {29'd0, fifo_count}, 32'd1);
    tick(1);
    check("t1_en", {31'd0, qtu_en}, 32'd1);
    check("t1_fsrc", {16'd0, fSourceID}, 32'h0005);
    tick(1);
    check("t1_en_pulse", {31'd0, qtu_en}, 32'd0);
    check("t1_busy_wait", {31'd0, busy}, 32'd1);
    tick(2);
    check("t1_busy_hold", {31'd0, busy}, 32'd1);
    qtu_done = 1'b1; tick(1); qtu_done = 1'b0;
    check("t1_idle", {31'd0, busy}, 32'd0);

    // fill queue behind a stalled update, then check full/backpressure and order
    sendPkt(16'h0011, 3'd1, 16'h0100);
    waitEn();
    sendPkt(16'h0012, 3'd2, 16'h0200);
    sendPkt(16'h0013, 3'd1, 16'h0300);
    sendPkt(16'h0014, 3'd2, 16'h0400);
    sendPkt(16'h0015, 3'd1, 16'h0500);
    check("t2_count_full", {29'd0, fifo_count}, 32'd4);
    check("t2_ready_low", {31'd0, pkt_ready}, 32'd0);
    pkt_valid = 1'b1; pkt_source_id = 16'h0016; pkt_type = 3'd1;
    tick(3);
    check("t2_stall_count", {29'd0, fifo_count}, 32'd4);
    qtu_done = 1'b1; tick(1); qtu_done = 1'b0;
    check("t2_count_after_done", {29'd0, fifo_count}, 32'd4);
    tick(1);
    check("t2_count_after_pop", {29'd0, fifo_count}, 32'd3);
    sendPkt(16'h0016, 3'd1, 16'h0600);
    repeat (5) completeOne();
    tick(3);
    check("t2_drained", {29'd0, fifo_count}, 32'd0);
    check("t2_idle", {31'd0, busy}, 32'd0);

    // type filter and drop saturation
    sendPkt(16'h0020, 3'd0, 16'h0001);
    sendPkt(16'h0021, 3'd2, 16'h0002);
    sendPkt(16'h0022, 3'd3, 16'h0003);
    sendPkt(16'h0023, 3'd2, 16'h0004);
    sendPkt(16'h0024, 3'd7, 16'h0005);
    completeOne();
    completeOne();
    check("t3_drops", {24'd0, drop_count}, 32'd3);
    for (int i = 0; i < 300; i++) sendPkt(16'(i), 3'd0, 16'h0);
    check("t3_drop_sat", {24'd0, drop_count}, 32'd255);
    tick(3);
    check("t3_idle", {31'd0, busy}, 32'd0);

`ifdef QTU_TIMEOUT_EN
    doReset();
    sendPkt(16'h0030, 3'd1, 16'h0030);
    waitEn();
    tick(1);
    check("t5_wait_first", {31'd0, busy}, 32'd1);
    tick(7);
    check("t5_wait_last", {31'd0, busy}, 32'd1);
    check("t5_flag_pre", {31'd0, timeout_flag}, 32'd0);
    tick(1);
    check("t5_abort_idle", {31'd0, busy}, 32'd0);
    check("t5_flag", {31'd0, timeout_flag}, 32'd1);
    sendPkt(16'h0031, 3'd2, 16'h0031);
    completeOne();
    tick(2);
    check("t5_flag_sticky", {31'd0, timeout_flag}, 32'd1);
    doReset();
    sendPkt(16'h0032, 3'd1, 16'h0032);
    waitEn();
    tick(8);
    qtu_done = 1'b1; tick(1); qtu_done = 1'b0;
    check("t6_idle", {31'd0, busy}, 32'd0);
    check("t6_no_flag", {31'd0, timeout_flag}, 32'd0);
`else
    sendPkt(16'h0030, 3'd1, 16'h0030);
    waitEn();
    tick(1000);
    check("t6_busy_forever", {31'd0, busy}, 32'd1);
    check("t6_flag_tied", {31'd0, timeout_flag}, 32'd0);
    completeOne();
    tick(1);
    check("t6_idle", {31'd0, busy}, 32'd0);
`endif

    // asynchronous reset mid-update with entries queued
    sendPkt(16'h0040, 3'd1, 16'h0040);
    waitEn();
    sendPkt(16'h0041, 3'd1, 16'h0041);
    sendPkt(16'h0042, 3'd2, 16'h0042);
    check("t4_queued", {29'd0, fifo_count}, 32'd2);
    #2 nrst = 1'b1;
    #1;
    check("t4_count", {29'd0, fifo_count}, 32'd0);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_fsrc", {16'd0, fSourceID}, 32'd0);
    check("t4_drop", {24'd0, drop_count}, 32'd0);
    sb.delete();
    tick(2);
    nrst = 1'b0;
    tick(10);
    check("t4_no_launch", {31'd0, busy}, 32'd0);
    check("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
